// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//   Move-queue sequencer between spi_state_machine and dda_timer. Holds up to
//   DEPTH move descriptors (direction, step count, DDA increment) in a ring
//   buffer and hands them to the DDA one at a time. halt aborts the running
//   move and flushes the queue.
//
// Optional feature macro: MOVE_SCHED_WATCHDOG_EN
//   Defined   : a WDT_W-bit stall counter runs while a move is in RUN; when it
//               reaches all-ones without a step_tick, fault is set and the
//               scheduler flushes exactly as on halt.
//   Undefined : no watchdog counter; fault is tied low.
//
// Ports
//   CLK            in   system clock
//   reset          in   asynchronous, active-high reset
//   wr_valid       in   enqueue strobe, one descriptor per cycle
//   wr_dir         in   descriptor direction
//   wr_steps       in   descriptor step count            [STEP_W]
//   wr_increment   in   descriptor DDA increment         [INC_W]
//   halt           in   abort and flush, level-sensitive
//   step_tick      in   one-cycle pulse per step from dda_timer
//   dda_load       out  one-cycle pulse: dda_increment/dda_dir are new
//   dda_increment  out  increment of the active move     [INC_W]
//   dda_dir        out  direction of the active move
//   dda_enable     out  high while a move is running
//   buffer_dtr     out  queue not full
//   move_done      out  one-cycle pulse on move completion
//   level          out  queued entries, excluding the active move
//   overflow       out  sticky: a write was dropped because the queue was full
//   fault          out  sticky watchdog trip
// -----------------------------------------------------------------------------
module move_scheduler #(
  parameter int DEPTH  = 4,
  parameter int STEP_W = 32,
  parameter int INC_W  = 64,
  parameter int WDT_W  = 24
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic                     wr_dir,
  input  logic [STEP_W-1:0]        wr_steps,
  input  logic [INC_W-1:0]         wr_increment,
  input  logic                     halt,
  input  logic                     step_tick,
  output logic                     dda_load,
  output logic [INC_W-1:0]         dda_increment,
  output logic                     dda_dir,
  output logic                     dda_enable,
  output logic                     buffer_dtr,
  output logic                     move_done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // Elaboration-time guard: the pointer arithmetic relies on natural wrap.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDT_W < 1) begin : g_bad_param
    $error("move_scheduler: DEPTH must be a power of 2 >= 2 and WDT_W >= 1");
  end

  typedef struct packed {
    logic              dir;
    logic [STEP_W-1:0] steps;
    logic [INC_W-1:0]  inc;
  } desc_t;

  desc_t             mem [DEPTH];
  desc_t             head;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [STEP_W-1:0] remaining;
  logic              dda_load_q;
  logic              full;
  logic              push;
  logic              pop;
  logic              flush;
  logic              wdt_trip;

  assign full       = (level == LW'(DEPTH));
  assign buffer_dtr = !full;
  assign head       = mem[rd_ptr];

  // A watchdog trip behaves like a one-cycle internal halt.
  assign flush = halt | wdt_trip;
  // The head is consumed in the LOAD cycle; LOAD is only entered with level != 0.
  assign pop   = (state == S_LOAD) && !flush;
  assign push  = wr_valid && !full && !flush;

  // halt masks the pulses combinationally so none escape during the halt cycle.
  assign dda_load   = dda_load_q && !halt;
  assign dda_enable = (state == S_RUN) && !halt;
  assign move_done  = (state == S_FINISH) && !halt;

  // NOTE: storage array has no reset; entries are only read after being written,
  // and leaving it out of the reset tree lets it map onto plain RAM/flops.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{dir: wr_dir, steps: wr_steps, inc: wr_increment};
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (level != '0) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = (head.steps == '0) ? S_FINISH : S_RUN;
      S_RUN:    if (step_tick && remaining == STEP_W'(1)) state_nxt = S_FINISH;
      S_FINISH: state_nxt = (level != '0) ? S_LOAD : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      remaining     <= '0;
      overflow      <= 1'b0;
      dda_load_q    <= 1'b0;
      dda_increment <= '0;
      dda_dir       <= 1'b0;
    end else begin
      state      <= state_nxt;
      dda_load_q <= pop;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        unique case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: ;
        endcase
      end

      if (halt)                  overflow <= 1'b0;
      else if (wr_valid && full) overflow <= 1'b1;

      // The DDA parameters survive a halt; only a new LOAD replaces them.
      if (pop) begin
        dda_increment <= head.inc;
        dda_dir       <= head.dir;
      end

      if (flush)                          remaining <= '0;
      else if (pop)                       remaining <= head.steps;
      else if (state == S_RUN && step_tick) remaining <= remaining - STEP_W'(1);
    end
  end

`ifdef MOVE_SCHED_WATCHDOG_EN
  logic [WDT_W-1:0] wdt_cnt;

  // Trip only when the counter is saturated and no step arrives this cycle.
  assign wdt_trip = (state == S_RUN) && !step_tick && (&wdt_cnt);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wdt_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      if (state != S_RUN || step_tick || flush) wdt_cnt <= '0;
      else                                      wdt_cnt <= wdt_cnt + WDT_W'(1);

      if (halt)          fault <= 1'b0;
      else if (wdt_trip) fault <= 1'b1;
    end
  end
`else
  assign wdt_trip = 1'b0;
  assign fault    = 1'b0;
`endif

endmodule
